itof_pipe: RTL and testbench

Pipelined signed-32-bit-integer to IEEE-754 single-precision converter for the FPU; the inverse of the `ftoi` unit. Three register stages with valid/ready flow control, round-to-nearest-even, a pass-through tag for the issue logic, and a synchronous flush. Sits in the FPU execute cluster between the integer-operand read port and the FP writeback arbiter.

---
 rtl/fpu_pkg.sv | 14 +
 rtl/lzc32.sv | 20 ++
 rtl/itof_pipe.sv | 141 ++++++++++++++
 tb/tb_itof_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision layout and exponent constants.
package fpu_pkg;

    localparam int FP_BIAS         = 127;
    // Exponent of an int whose MSB sits at bit 31 after normalization: 127 + 31.
    localparam int INT2FP_EXP_BASE = 158;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; zero flags an all-zero input.
module lzc32 (
    input  logic [31:0] mag,
    output logic [4:0]  cnt,
    output logic        zero
);

    // Scan upward so the highest set bit wins and sets the final count.
    always_comb begin
        cnt  = 5'd0;
        zero = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                cnt  = 5'(31 - i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 -> IEEE single converter with valid/ready flow control,
// round-to-nearest-even, pass-through tag and synchronous flush.
module itof_pipe
    import fpu_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic             r_vld_p1, r_vld_p2, r_vld_p3;
    logic             r_sign_p1;
    logic [31:0]      r_mag_p1;
    logic [TAG_W-1:0] r_tag_p1;
    logic             r_sign_p2, r_zero_p2;
    logic [4:0]       r_lz_p2;
    logic [31:0]      r_norm_p2;
    logic [TAG_W-1:0] r_tag_p2;
    fp32_t            r_res_p3;
    logic [TAG_W-1:0] r_tag_p3;

    logic             w_adv_p1, w_adv_p2, w_adv_p3;
    logic             w_take;
    logic signed [31:0] w_in_s;
    logic [31:0]      w_mag_p0;
    logic [4:0]       w_lz_p1;
    logic             w_zero_p1;
    logic [31:0]      w_norm_p1;
    fp32_t            w_res_p2;

    // Exponent from leading-zero count, RNE on guard/sticky, carry folds into exponent.
    function automatic fp32_t round_pack(input logic sign, input logic zero,
                                         input logic [4:0] lz, input logic [31:0] norm);
        logic [23:0] sum;
        logic [7:0]  e8;
        logic        guard, sticky, up;
        fp32_t       res;
        e8     = 8'(INT2FP_EXP_BASE) - {3'b000, lz};
        guard  = norm[7];
        sticky = |norm[6:0];
        up     = guard && (sticky || norm[8]);
        sum    = {1'b0, norm[30:8]} + {23'd0, up};
        if (sum[23]) begin
            e8 = e8 + 8'd1;
        end
        res.sign = sign;
        res.exp  = e8;
        res.frac = sum[22:0];
        if (zero) begin
            res = '0;
        end
        return res;
    endfunction

    // A stage moves forward when it holds data and its successor is empty or moving.
    assign w_adv_p3 = r_vld_p3 && out_ready;
    assign w_adv_p2 = r_vld_p2 && (!r_vld_p3 || w_adv_p3);
    assign w_adv_p1 = r_vld_p1 && (!r_vld_p2 || w_adv_p2);
    assign in_ready = !r_vld_p1 || w_adv_p1;
    assign w_take   = in_valid && in_ready;

    // ---- p0 -> p1: sign/magnitude capture (0x80000000 negates to itself) ----
    assign w_in_s   = in_data;
    assign w_mag_p0 = in_data[31] ? 32'(-w_in_s) : in_data;

    // ---- p1 -> p2: normalize ----
    lzc32 u_lzc (
        .mag  (r_mag_p1),
        .cnt  (w_lz_p1),
        .zero (w_zero_p1)
    );
    assign w_norm_p1 = r_mag_p1 << w_lz_p1;

    // ---- p2 -> p3: round and pack ----
    assign w_res_p2 = round_pack(r_sign_p2, r_zero_p2, r_lz_p2, r_norm_p2);

    // Stage occupancy; flush empties every stage on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else if (flush) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else begin
            if (in_ready)               r_vld_p1 <= in_valid;
            if (!r_vld_p2 || w_adv_p2)  r_vld_p2 <= r_vld_p1;
            if (!r_vld_p3 || w_adv_p3)  r_vld_p3 <= r_vld_p2;
        end
    end

    // Payload and tag move only with a transfer, so stalled stages hold steady.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sign_p1 <= 1'b0;
            r_mag_p1  <= '0;
            r_tag_p1  <= '0;
            r_sign_p2 <= 1'b0;
            r_zero_p2 <= 1'b0;
            r_lz_p2   <= '0;
            r_norm_p2 <= '0;
            r_tag_p2  <= '0;
            r_res_p3  <= '0;
            r_tag_p3  <= '0;
        end else begin
            if (w_take) begin
                r_sign_p1 <= in_data[31];
                r_mag_p1  <= w_mag_p0;
                r_tag_p1  <= in_tag;
            end
            if (w_adv_p1) begin
                r_sign_p2 <= r_sign_p1;
                r_zero_p2 <= w_zero_p1;
                r_lz_p2   <= w_lz_p1;
                r_norm_p2 <= w_norm_p1;
                r_tag_p2  <= r_tag_p1;
            end
            if (w_adv_p2) begin
                r_res_p3  <= w_res_p2;
                r_tag_p3  <= r_tag_p2;
            end
        end
    end

    assign out_valid = r_vld_p3;
    assign out_data  = r_res_p3;
    assign out_tag   = r_tag_p3;

endmodule

// File: tb/tb_itof_pipe.sv
// Bench for itof_pipe: directed corner cases plus randomized traffic against an
// arithmetic reference model, with a scoreboard checking every output transfer.
module tb_itof_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [5:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [5:0]  out_tag;

    int n_chk = 0;
    int n_fail = 0;
    int n_sent = 0;
    int base;
    logic [31:0] q_d[$];
    logic [5:0]  q_t[$];
    logic        stall_prev = 1'b0;
    logic [31:0] hold_d;
    logic [5:0]  hold_t;
    logic        rnd_on = 1'b0;
    logic [31:0] x;
    logic [31:0] vals[5];

    always #5 clk = ~clk;

    itof_pipe #(.TAG_W(6)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tg, got, exp, $time);
        end
    endtask

    // Reference: exact integer scaling with round-half-to-even on the discarded bits.
    function automatic logic [31:0] ref_itof(input logic [31:0] v);
        longint sv, m, q, rem, half;
        int     e, sh;
        logic   s;
        if (v == 32'd0) return 32'd0;
        s  = v[31];
        sv = longint'(signed'(v));
        m  = s ? -sv : sv;
        e  = 31;
        while (((m >> e) & 64'd1) == 64'd0) e--;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            sh   = e - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    task automatic push(input logic [31:0] e, input logic [5:0] t);
        q_d.push_back(e);
        q_t.push_back(t);
        n_sent++;
    endtask

    // Present one operand (called just after a rising edge) and hold it until accepted.
    task automatic send(input logic [31:0] d, input logic [5:0] t, input logic [31:0] e);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (in_ready && rstn && !flush) begin
                push(e, t);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) chk("send_timeout", 32'(got), 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q_d.size() != 0 || out_valid) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_left", q_d.size(), 32'd0);
    endtask

    // Scoreboard: every accepted output must match the oldest pending expectation,
    // and a stalled output must not change.
    always @(negedge clk) begin
        if (!rstn || flush) begin
            q_d.delete();
            q_t.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_vld", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, hold_d);
                chk("hold_tag", 32'(out_tag), 32'(hold_t));
            end
            if (out_valid && out_ready) begin
                if (q_d.size() == 0) begin
                    chk("unexp_out", q_d.size(), 32'd1);
                end else begin
                    chk("res_data", out_data, q_d.pop_front());
                    chk("res_tag", 32'(out_tag), 32'(q_t.pop_front()));
                end
            end
            stall_prev = out_valid && !out_ready;
            hold_d = out_data;
            hold_t = out_tag;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // 1, -1, 0 back-to-back: first result on the third edge counting acceptance
        in_valid = 1'b1; in_data = 32'd1; in_tag = 6'd1;
        @(negedge clk); chk("b2b_rdy0", 32'(in_ready), 32'd1); push(32'h3F800000, 6'd1);
        @(posedge clk); #1; in_data = 32'hFFFFFFFF; in_tag = 6'd2;
        @(negedge clk); chk("lat_e0", 32'(out_valid), 32'd0); push(32'hBF800000, 6'd2);
        @(posedge clk); #1; in_data = 32'd0; in_tag = 6'd3;
        @(negedge clk); chk("lat_e1", 32'(out_valid), 32'd0); push(32'h00000000, 6'd3);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_v0", 32'(out_valid), 32'd1); chk("b2b_d0", out_data, 32'h3F800000);
        chk("b2b_t0", 32'(out_tag), 32'd1);
        @(negedge clk);
        chk("b2b_v1", 32'(out_valid), 32'd1); chk("b2b_d1", out_data, 32'hBF800000);
        chk("b2b_t1", 32'(out_tag), 32'd2);
        @(negedge clk);
        chk("b2b_v2", 32'(out_valid), 32'd1); chk("b2b_d2", out_data, 32'h00000000);
        chk("b2b_t2", 32'(out_tag), 32'd3);
        @(posedge clk); #1;
        drain();

        // Extremes and rounding ties
        send(32'h80000000, 6'd4, 32'hCF000000);
        send(32'h7FFFFFFF, 6'd5, 32'h4F000000);
        send(32'd16777217, 6'd6, 32'h4B800000);
        send(32'd16777219, 6'd7, 32'h4B800002);
        send(32'd16777221, 6'd8, 32'h4B800002);
        drain();

        // Backpressure: 5 offered, 3 held, then drain in order
        vals[0] = 32'd7;  vals[1] = 32'hFFFFFF00; vals[2] = 32'd123456789;
        vals[3] = 32'd33554435; vals[4] = 32'hF0000001;
        out_ready = 1'b0;
        base = n_sent;
        fork
            begin
                for (int i = 0; i < 5; i++) send(vals[i], 6'(10 + i), ref_itof(vals[i]));
                in_valid = 1'b0;
            end
            begin
                repeat (8) @(negedge clk);
                chk("stall_accepted", 32'(n_sent - base), 32'd3);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk); #1;
                out_ready = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("drain_rate", 32'(out_valid), 32'd1);
                end
            end
        join
        @(posedge clk); #1;
        drain();

        // Flush a full pipe, with a new operand offered on the flush cycle
        out_ready = 1'b0;
        send(32'd40, 6'd40, ref_itof(32'd40));
        send(32'd41, 6'd41, ref_itof(32'd41));
        send(32'd42, 6'd42, ref_itof(32'd42));
        flush = 1'b1; in_valid = 1'b1; in_data = 32'd43; in_tag = 6'd43;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("flush_quiet", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(32'hFFFFFFFD, 6'd44, 32'hC0400000);
        drain();

        // Asynchronous reset mid-stream
        send(32'd50, 6'd50, ref_itof(32'd50));
        send(32'd51, 6'd51, ref_itof(32'd51));
        send(32'd52, 6'd52, ref_itof(32'd52));
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_out_tag", 32'(out_tag), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        send(32'd1000, 6'd53, 32'h447A0000);
        drain();

        // Randomized traffic with random backpressure and idle gaps
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: x = $urandom;
                1: x = 32'($urandom_range(0, 32'h2000000)) - 32'h1000000;
                2: x = ($urandom & 32'h7FFFFF80) | 32'($urandom_range(0, 1) << 6);
                default: x = ($urandom_range(0, 1) != 0) ? 32'h80000000 : -32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            send(x, 6'($urandom), ref_itof(x));
        end
        in_valid = 1'b0;
        rnd_on = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
